// File: rtl/can_host_seq.sv
// can_host_seq: CPU-bus host sequencer for the CAN controller.
// Programs the controller from a fixed init table after reset, then serves
// transmit (header + payload writes) and receive (header + payload reads)
// requests over the cpu_* register port.
// Optional feature: define CAN_HOST_TIMEOUT_EN to build the per-access ack
// watchdog; without it accesses wait for cpu_ack indefinitely.
module can_host_seq #(
  parameter int unsigned DATA_WORDS  = 2,
  parameter int unsigned INIT_DELAY  = 3500,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] TX_ADDR     = 32'h0000_0204,
  parameter logic [31:0] RX_ADDR     = 32'h0000_0200
) (
  input  logic                    sysclk,
  input  logic                    ponrst,
  input  logic                    send,
  input  logic                    rec,
  input  logic [10:0]             tx_id,
  input  logic [6:0]              tx_dlc,
  input  logic [32*DATA_WORDS-1:0] tx_data,
  output logic [63:0]             rx_hdr,
  output logic [32*DATA_WORDS-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    tx_done,
  output logic                    init_done,
  output logic                    busy,
  output logic                    err,
  output logic                    cpu_cs,
  output logic                    cpu_write,
  output logic                    cpu_read,
  output logic [31:0]             cpu_addr,
  output logic [31:0]             cpu_wdat,
  input  logic [31:0]             cpu_rdat,
  input  logic                    cpu_ack,
  input  logic                    cpu_err
);

  localparam int unsigned N_FRAME    = DATA_WORDS + 2;
  localparam logic [4:0]  INIT_LAST  = 5'd9;
  localparam logic [4:0]  FRAME_LAST = 5'(N_FRAME - 1);
  localparam logic [31:0] DELAY_LAST = 32'(INIT_DELAY - 1);

  typedef enum logic [2:0] {S_WAIT, S_INIT, S_IDLE, S_TX, S_RX, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] delay_q, delay_d;
  logic [4:0]  idx_q, idx_d;
  logic        cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [31:0] addr_q, addr_d, wdat_q, wdat_d;
  logic        send_pend_q, send_pend_d, rec_pend_q, rec_pend_d;
  logic        init_done_q, init_done_d, err_q, err_d, busy_q, busy_d;
  logic        tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
  logic [63:0] rx_hdr_q;
  logic [32*DATA_WORDS-1:0] rx_data_q;

  logic        tx_capture, stage_we, rx_commit, abort;
  logic [10:0] tx_id_q;
  logic [6:0]  tx_dlc_q;
  logic [31:0] tx_word_q [DATA_WORDS];
  logic [31:0] stage_q [N_FRAME];
  logic [31:0] acc_addr, acc_wdat;
  logic        acc_wr;
  logic [4:0]  last_idx;

`ifdef CAN_HOST_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(ACK_TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
`endif

  // Controller init table: {address, data} for entry i.
  function automatic logic [63:0] init_entry(input logic [4:0] i);
    case (i)
      5'd0:    init_entry = {32'h0000_0008, 32'h0000_000A};
      5'd1:    init_entry = {32'h0000_000C, 32'h0100_0404};
      5'd2:    init_entry = {32'h0000_0010, 32'h0100_0404};
      5'd3:    init_entry = {32'h0000_0040, 32'h0003_0000};
      5'd4:    init_entry = {32'h0000_0044, 32'h0007_0004};
      5'd5:    init_entry = {32'h0000_0048, 32'h000F_0008};
      5'd6:    init_entry = {32'h0000_0024, 32'h0000_0001};
      5'd7:    init_entry = {32'h0000_0100, 32'h8000_0000};
      5'd8:    init_entry = {32'h0000_0104, 32'hA000_0000};
      default: init_entry = {32'h0000_0004, 32'h0000_0001};
    endcase
  endfunction

  // Address, data and direction of access idx_q in the current sequence.
  always_comb begin
    acc_addr = '0;
    acc_wdat = '0;
    acc_wr   = 1'b0;
    last_idx = FRAME_LAST;
    unique case (state_q)
      S_INIT: begin
        {acc_addr, acc_wdat} = init_entry(idx_q);
        acc_wr   = 1'b1;
        last_idx = INIT_LAST;
      end
      S_TX: begin
        acc_addr = TX_ADDR;
        acc_wr   = 1'b1;
        if (idx_q == 5'd0)      acc_wdat = {3'b000, tx_id_q, 18'b0};
        else if (idx_q == 5'd1) acc_wdat = {25'b0, tx_dlc_q};
        for (int k = 0; k < DATA_WORDS; k++)
          if (idx_q == 5'(k + 2)) acc_wdat = tx_word_q[k];
      end
      S_RX:    acc_addr = RX_ADDR;
      default: ;
    endcase
  end

  // Sequencer next state: request latching, access launch/ack/abort.
  // NOTE: blocking assignments in combinational logic, and every target gets
  // a default first so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    idx_d       = idx_q;
    cs_d        = cs_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    tx_done_d   = 1'b0;
    rx_valid_d  = 1'b0;
    send_pend_d = send_pend_q | (send & init_done_q);
    rec_pend_d  = rec_pend_q | (rec & init_done_q);
    tx_capture  = 1'b0;
    stage_we    = 1'b0;
    rx_commit   = 1'b0;
    abort       = 1'b0;
`ifdef CAN_HOST_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    unique case (state_q)
      S_WAIT: begin
        if (delay_q == DELAY_LAST) begin
          state_d = S_INIT;
          idx_d   = '0;
        end else begin
          delay_d = delay_q + 32'd1;
        end
      end
      S_IDLE: begin
        // A pulse arriving in the take cycle re-latches rather than being lost.
        if (send_pend_q) begin
          state_d     = S_TX;
          idx_d       = '0;
          tx_capture  = 1'b1;
          send_pend_d = send & init_done_q;
        end else if (rec_pend_q) begin
          state_d    = S_RX;
          idx_d      = '0;
          rec_pend_d = rec & init_done_q;
        end
      end
      S_INIT, S_TX, S_RX: begin
        if (!cs_q) begin
          cs_d   = 1'b1;
          wr_d   = acc_wr;
          rd_d   = ~acc_wr;
          addr_d = acc_addr;
          wdat_d = acc_wdat;
`ifdef CAN_HOST_TIMEOUT_EN
          wd_d   = '0;
`endif
        end else if (cpu_ack) begin
          cs_d   = 1'b0;
          wr_d   = 1'b0;
          rd_d   = 1'b0;
          addr_d = '0;
          wdat_d = '0;
          if (cpu_err) begin
            abort = 1'b1;
          end else begin
            stage_we = (state_q == S_RX);
            if (idx_q == last_idx) begin
              state_d     = S_IDLE;
              init_done_d = init_done_q | (state_q == S_INIT);
              tx_done_d   = (state_q == S_TX);
              rx_valid_d  = (state_q == S_RX);
              rx_commit   = (state_q == S_RX);
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
`ifdef CAN_HOST_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
        if (abort) begin
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          addr_d  = '0;
          wdat_d  = '0;
          err_d   = 1'b1;
          state_d = (state_q == S_INIT) ? S_HALT : S_IDLE;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control and bus registers; reset returns to WAIT with the bus released.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk or posedge ponrst) begin
    if (ponrst) begin
      state_q     <= S_WAIT;
      delay_q     <= '0;
      idx_q       <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
      send_pend_q <= 1'b0;
      rec_pend_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      idx_q       <= idx_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      send_pend_q <= send_pend_d;
      rec_pend_q  <= rec_pend_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

`ifdef CAN_HOST_TIMEOUT_EN
  // Ack watchdog: cs-high cycles of the current access.
  always_ff @(posedge sysclk or posedge ponrst) begin
    if (ponrst) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  // Received frame becomes visible only once every read has completed.
  always_ff @(posedge sysclk or posedge ponrst) begin
    if (ponrst) begin
      rx_hdr_q  <= '0;
      rx_data_q <= '0;
    end else if (rx_commit) begin
      rx_hdr_q <= {stage_q[0], stage_q[1]};
      for (int k = 0; k < DATA_WORDS; k++)
        rx_data_q[32*k +: 32] <= (k == DATA_WORDS - 1) ? cpu_rdat : stage_q[k + 2];
    end
  end

  // TX frame capture on entry and RX read staging.
  // NOTE: pure datapath storage, written before it is ever read, so it carries
  // no reset.
  always_ff @(posedge sysclk) begin
    if (tx_capture) begin
      tx_id_q  <= tx_id;
      tx_dlc_q <= tx_dlc;
      for (int k = 0; k < DATA_WORDS; k++) tx_word_q[k] <= tx_data[32*k +: 32];
    end
    if (stage_we) begin
      for (int k = 0; k < N_FRAME; k++)
        if (idx_q == 5'(k)) stage_q[k] <= cpu_rdat;
    end
  end

  assign cpu_cs    = cs_q;
  assign cpu_write = wr_q;
  assign cpu_read  = rd_q;
  assign cpu_addr  = addr_q;
  assign cpu_wdat  = wdat_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign rx_valid  = rx_valid_q;
  assign rx_hdr    = rx_hdr_q;
  assign rx_data   = rx_data_q;

endmodule

// File: doc/can_host_seq.md
# can_host_seq

Parametrised CPU-bus host sequencer for the CAN controller. After reset it programs the controller's timing, buffer, interrupt, filter and command registers from a fixed init table. It then services transmit requests (header plus DATA_WORDS payload writes to the TX port) and receive requests (header plus payload reads from the RX port), with per-access ack watchdog and error reporting. It sits between the board-level control logic and the controller's cpu_* register port, and generalises the fixed 2-word bench driver.

## Interface
- DATA_WORDS, 2: payload words per frame, 1..16.
- INIT_DELAY, 3500: cycles from reset release to first init write, ≥1.
- ACK_TIMEOUT, 255: max cycles cpu_cs may wait for cpu_ack, 1..65535.
- TX_ADDR, 32'h0204: TX buffer port address.
- RX_ADDR, 32'h0200: RX buffer port address.

Ports:
- sysclk  in  1  system clock; all logic rising-edge.
- ponrst  in  1  reset, asynchronous, active-high.
- send  in  1  transmit request pulse.
- rec  in  1  receive request pulse.
- tx_id  in  11  base identifier.
- tx_dlc  in  7  header NUMBYTES field.
- tx_data  in  32*DATA_WORDS  payload; word k = bits [32k+31:32k].
- rx_hdr  out  64  {hdr1, hdr2} read from RX port.
- rx_data  out  32*DATA_WORDS  received payload, same packing.
- rx_valid  out  1  one-cycle pulse, rx_* updated.
- tx_done  out  1  one-cycle pulse, frame fully written.
- init_done  out  1  level, init table complete.
- busy  out  1  state is not IDLE.
- err  out  1  sticky; cleared only by reset.
- cpu_cs, cpu_write, cpu_read  out  1  access strobes.
- cpu_addr, cpu_wdat  out  32  access address/write data.
- cpu_rdat  in  32  read data, valid with cpu_ack.
- cpu_ack, cpu_err  in  1  access complete / access failed.

## Operation
- States: WAIT, INIT, IDLE, TX, RX, HALT.
- WAIT: count INIT_DELAY cycles, then INIT.
- INIT: 10 writes in order: 008←0000000A, 00C←01000404, 010←01000404, 040←00030000, 044←00070004, 048←000F0008, 024←00000001, 100←80000000, 104←A0000000, 004←00000001. Then init_done=1, go to IDLE.
- Request latching: send/rec pulses set send_pend/rec_pend whenever init_done=1, including while busy. Each is cleared when its sequence starts. Repeated pulses before service collapse to one.
- IDLE: send_pend has priority over rec_pend. When both are pending, TX runs first and RX follows.
- TX: tx_id/tx_dlc/tx_data are captured on entry. 2+DATA_WORDS writes to TX_ADDR: {3'b000,tx_id,18'b0}, {1'b0,24'b0,tx_dlc}, then word 0..DATA_WORDS-1. tx_done pulses when the last ack is accepted.
- RX: 2+DATA_WORDS reads from RX_ADDR. The first two fill rx_hdr[63:32] and rx_hdr[31:0]; the rest fill rx_data words 0 upward. rx_valid pulses after the last read; rx_* hold their values until the next RX completes.
- Error: cpu_err with cpu_ack, or watchdog expiry, sets err and aborts the sequence.
  - Abort in INIT goes to HALT, which is terminal until reset.
  - Abort in TX/RX goes to IDLE without tx_done/rx_valid; partial rx_* are not exposed.

## Timing
- All outputs reset to 0; state resets to WAIT.
- An access drives cpu_cs=1, the write or read strobe, cpu_addr and cpu_wdat from registers, held stable until cpu_ack is sampled high.
- In the cycle after the ack: cs and strobes are 0 for exactly one cycle, then the next access starts. Per access: ack latency + 2 cycles.
- cpu_wdat=0 for reads and whenever cs=0. cpu_addr=0 whenever cs=0.
- The watchdog counts cs-high cycles without ack. When the count reaches ACK_TIMEOUT, the controller drops cs and sets err.
- tx_done/rx_valid assert the cycle after the final ack; busy falls in the same cycle.
- A send pulse in the cycle an idle request is taken is latched, not lost.
- Reset asserted mid-access forces cs=0 immediately (asynchronous) and restarts from WAIT.

## Configuration
- CAN_HOST_TIMEOUT_EN defined: ack watchdog present, as above.
- CAN_HOST_TIMEOUT_EN undefined: no watchdog; accesses wait for ack indefinitely, and err is set only by cpu_err.

## Test plan
- Reset release with ack after 2 cycles: exactly 10 init writes with the listed addr/data, then init_done=1 at INIT_DELAY+40 cycles.
- DATA_WORDS=2, tx_id=11'h555, tx_dlc=8, data {88888888,7C01A579}: writes 15540000, 00000008, 7C01A579, 88888888 to 0x204, then one tx_done pulse.
- send and rec in the same cycle: full TX sequence, then full RX. rx_data equals the bench read values; one rx_valid pulse.
- ack withheld on the 3rd TX write, ACK_TIMEOUT=16: cs drops after 16 cycles, err=1, no tx_done, returns to IDLE. With the macro undefined, cs stays high.
- cpu_err on the 5th init write: err=1, state HALT, init_done stays 0, later send ignored.
- DATA_WORDS=16, reset pulsed mid-RX: outputs 0, rx_valid never pulses, init reruns.
